// File: rtl/io_dispatch_pkg.sv
// Shared I/O definitions for the CPU-side dispatcher and the IOP.
// Holds the function codes, the no-IOP condition code and the dispatcher state encoding.
package io_defs;

   localparam logic [2:0] FNC_SIO = 3'd0;
   localparam logic [2:0] FNC_TIO = 3'd1;
   localparam logic [2:0] FNC_TDV = 3'd2;
   localparam logic [2:0] FNC_HIO = 3'd3;
   localparam logic [2:0] FNC_AIO = 3'd6;

   localparam logic [1:0] CC_NO_IOP = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_BUS,
      ST_ACTIVE,
      ST_RESPOND,
      ST_DRAIN
   } state_t;

   // Codes 4, 5 and 7 have no meaning to the IOP and are rejected up front.
   function automatic logic func_is_valid(input logic [2:0] func);
      case (func)
         FNC_SIO, FNC_TIO, FNC_TDV, FNC_HIO, FNC_AIO: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/io_dispatch.sv
// Sequences one CPU I/O instruction onto the IOP: validate, take the memory bus,
// hold the IOP active for a per-function cycle count, then return the condition code.
module io_dispatch
   import io_defs::*;
#(
   parameter logic [2:0] IOP_ADDR     = 3'd0,
   parameter int         SIO_CYCLES   = 4,
   parameter int         OTHER_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic [0:2] cpu_func,
   input  logic [0:2] cpu_addr,
   input  logic       cpu_bus_idle,
   output logic       cpu_hold,
   output logic       cpu_ack,
   output logic [0:1] cpu_cc,
   output logic       iop_active,
   output logic [0:2] iop_func,
   output logic [0:2] iop_addr,
   input  logic [0:1] iop_cc
);

   localparam int MAX_CYCLES = (SIO_CYCLES > OTHER_CYCLES) ? SIO_CYCLES : OTHER_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] SIO_LOAD   = CNT_W'(SIO_CYCLES - 1);
   localparam logic [CNT_W-1:0] OTHER_LOAD = CNT_W'(OTHER_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] count;

   // Single registered FSM. The counter holds the remaining ACTIVE cycles minus one,
   // so the IOP sees active for exactly the configured number of cycles.
   // A rejected request enters RESPOND with the ack still low and raises it there,
   // which gives the one extra cycle of latency that rejected requests carry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         count      <= '0;
         cpu_hold   <= 1'b0;
         cpu_ack    <= 1'b0;
         cpu_cc     <= 2'b00;
         iop_active <= 1'b0;
         iop_func   <= 3'b000;
         iop_addr   <= 3'b000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  iop_func <= cpu_func;
                  iop_addr <= cpu_addr;
                  if (!func_is_valid(cpu_func) || (cpu_addr != IOP_ADDR)) begin
                     cpu_cc <= CC_NO_IOP;
                     state  <= ST_RESPOND;
                  end else begin
                     cpu_hold <= 1'b1;
                     state    <= ST_WAIT_BUS;
                  end
               end
            end

            ST_WAIT_BUS: begin
               if (cpu_bus_idle) begin
                  iop_active <= 1'b1;
                  count      <= (iop_func == FNC_SIO) ? SIO_LOAD : OTHER_LOAD;
                  state      <= ST_ACTIVE;
               end
            end

            ST_ACTIVE: begin
               if (count == '0) begin
                  iop_active <= 1'b0;
                  cpu_hold   <= 1'b0;
                  cpu_cc     <= iop_cc;
                  cpu_ack    <= 1'b1;
                  state      <= ST_RESPOND;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end

            ST_RESPOND: begin
               if (cpu_ack) begin
                  cpu_ack <= 1'b0;
                  state   <= ST_DRAIN;
               end else begin
                  cpu_ack <= 1'b1;
               end
            end

            ST_DRAIN: begin
               if (!cpu_req) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_dispatch.sv
// Randomized scoreboard bench for io_dispatch: the driver predicts each ack,
// a negedge monitor pops predictions and compares timing, code and bus ownership.
module tb_io_dispatch;

   logic       clock = 1'b0;
   logic       reset;
   logic       cpu_req;
   logic [0:2] cpu_func;
   logic [0:2] cpu_addr;
   logic       cpu_bus_idle;
   logic       cpu_hold;
   logic       cpu_ack;
   logic [0:1] cpu_cc;
   logic       iop_active;
   logic [0:2] iop_func;
   logic [0:2] iop_addr;
   logic [0:1] iop_cc;

   io_dispatch dut (
      .clock        (clock),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .cpu_func     (cpu_func),
      .cpu_addr     (cpu_addr),
      .cpu_bus_idle (cpu_bus_idle),
      .cpu_hold     (cpu_hold),
      .cpu_ack      (cpu_ack),
      .cpu_cc       (cpu_cc),
      .iop_active   (iop_active),
      .iop_func     (iop_func),
      .iop_addr     (iop_addr),
      .iop_cc       (iop_cc)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] cc;
      int         ack_edge;
      int         act_cycles;
      int         hold_cycles;
      logic [2:0] func;
      logic [2:0] addr;
   } exp_t;

   exp_t sb[$];
   exp_t head;
   int   checks = 0;
   int   errors = 0;
   int   act_cnt = 0;
   int   hold_cnt = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: sample away from the rising edge and compare whenever an ack appears
   always @(negedge clock) begin
      if (!reset) begin
         act_cnt  = 0;
         hold_cnt = 0;
      end else begin
         if (iop_active) begin
            act_cnt++;
            checkOutput("hold_during_active", int'(cpu_hold), 1);
            if (sb.size() > 0) begin
               checkOutput("iop_func", int'(iop_func), int'(sb[0].func));
               checkOutput("iop_addr", int'(iop_addr), int'(sb[0].addr));
            end
         end
         if (cpu_hold) hold_cnt++;
         if (cpu_ack) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_ack", int'(cpu_ack), 0);
            end else begin
               head = sb.pop_front();
               checkOutput("ack_cycle", cyc, head.ack_edge);
               checkOutput("cpu_cc", int'(cpu_cc), int'(head.cc));
               checkOutput("active_cycles", act_cnt, head.act_cycles);
               checkOutput("hold_cycles", hold_cnt, head.hold_cycles);
            end
            act_cnt  = 0;
            hold_cnt = 0;
         end
      end
   end

   // Drives one request and predicts its outcome from the function/address rules.
   // idle_delay: cycles the bus stays busy after acceptance; extra: cycles req is
   // held past the ack; early_drop releases req right after acceptance.
   task automatic applyStimulus(input logic [2:0] f, input logic [2:0] a, input int idle_delay,
                                input int extra, input bit early_drop);
      bit         valid;
      int         n;
      int         e0;
      int         ack_edge;
      logic [1:0] cc_raw;
      exp_t       e;
      valid    = (f inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6}) && (a == 3'd0);
      n        = (f == 3'd0) ? 4 : 1;
      e0       = cyc + 1;
      ack_edge = valid ? (e0 + idle_delay + n + 1) : (e0 + 1);
      cc_raw   = 2'($urandom);
      e.cc          = valid ? cc_raw : 2'b11;
      e.ack_edge    = ack_edge;
      e.act_cycles  = valid ? n : 0;
      e.hold_cycles = valid ? (idle_delay + n + 1) : 0;
      e.func        = f;
      e.addr        = a;
      sb.push_back(e);
      cpu_req      = 1'b1;
      cpu_func     = f;
      cpu_addr     = a;
      cpu_bus_idle = (idle_delay == 0);
      iop_cc       = 2'($urandom);
      while (cyc < ack_edge + extra) begin
         @(posedge clock); #2;
         if (cyc >= e0) begin
            cpu_func = 3'($urandom);
            cpu_addr = 3'($urandom);
         end
         if (cyc == e0 + idle_delay) cpu_bus_idle = 1'b1;
         iop_cc = (cyc == ack_edge - 1) ? cc_raw : 2'($urandom);
         if (early_drop && cyc == e0) cpu_req = 1'b0;
      end
      cpu_req = 1'b0;
      @(posedge clock); #2;
      if (extra == 0) begin
         @(posedge clock); #2;
      end
   endtask

   // SIO interrupted by reset during its third ACTIVE cycle; no ack may follow
   task automatic resetMidSio();
      int e0;
      e0           = cyc + 1;
      cpu_func     = 3'd0;
      cpu_addr     = 3'd0;
      cpu_bus_idle = 1'b1;
      iop_cc       = 2'b01;
      cpu_req      = 1'b1;
      while (cyc < e0 + 3) begin
         @(posedge clock); #2;
      end
      checkOutput("pre_reset_active", int'(iop_active), 1);
      reset = 1'b0;
      #1;
      checkOutput("async_reset_active", int'(iop_active), 0);
      checkOutput("async_reset_hold", int'(cpu_hold), 0);
      checkOutput("async_reset_ack", int'(cpu_ack), 0);
      @(posedge clock); #2;
      cpu_req = 1'b0;
      @(posedge clock); #2;
      reset = 1'b1;
      repeat (4) begin
         @(posedge clock); #2;
      end
      checkOutput("post_reset_cc", int'(cpu_cc), 0);
      checkOutput("post_reset_hold", int'(cpu_hold), 0);
   endtask

   initial begin
      reset        = 1'b0;
      cpu_req      = 1'b1;
      cpu_func     = 3'd1;
      cpu_addr     = 3'd0;
      cpu_bus_idle = 1'b1;
      iop_cc       = 2'b10;
      repeat (3) begin
         @(posedge clock); #2;
         checkOutput("reset_ack", int'(cpu_ack), 0);
         checkOutput("reset_active", int'(iop_active), 0);
      end
      checkOutput("reset_hold", int'(cpu_hold), 0);
      checkOutput("reset_cc", int'(cpu_cc), 0);
      checkOutput("reset_iop_func", int'(iop_func), 0);
      checkOutput("reset_iop_addr", int'(iop_addr), 0);
      reset = 1'b1;

      applyStimulus(3'd1, 3'd0, 0, 1, 1'b0);
      applyStimulus(3'd0, 3'd0, 0, 1, 1'b0);
      applyStimulus(3'd1, 3'd0, 3, 0, 1'b0);
      applyStimulus(3'd5, 3'd0, 0, 1, 1'b0);
      applyStimulus(3'd0, 3'd3, 0, 0, 1'b0);
      applyStimulus(3'd0, 3'd0, 0, 20, 1'b0);
      applyStimulus(3'd6, 3'd0, 2, 1, 1'b0);
      resetMidSio();
      applyStimulus(3'd0, 3'd0, 1, 0, 1'b1);

      for (int i = 0; i < 60; i++) begin
         applyStimulus(3'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                       $urandom_range(0, 4),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2),
                       ($urandom_range(0, 3) == 0));
      end

      repeat (5) begin
         @(posedge clock); #2;
      end
      checkOutput("pending_acks", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_dispatch.md
# io_dispatch

Sequencer between the CPU's I/O instruction decode and the IOP. Accepts one I/O instruction (function plus IOP address) from the CPU and validates it. It obtains the shared memory bus by holding the CPU off, then drives the IOP `active`/`iop_func`/`iop_addr` inputs for a fixed per-function number of cycles. Finally it returns the IOP condition code to the CPU with a four-phase request/acknowledge handshake.

## Interface
Parameters:
- `IOP_ADDR`, 0 — address of the single attached IOP; any other `cpu_addr` is rejected.
- `SIO_CYCLES`, 4 — cycles `iop_active` is held for SIO; covers the IOP's four-phase SIO write sequence.
- `OTHER_CYCLES`, 1 — cycles `iop_active` is held for TIO/TDV/HIO/AIO.

Ports:
- `clock` in 1 — the only clock; all state changes on rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `cpu_req` in 1 — CPU requests an I/O operation; held high until `cpu_ack` is seen.
- `cpu_func` in [0:2] — I/O function code, valid while `cpu_req` is high.
- `cpu_addr` in [0:2] — target IOP address, valid while `cpu_req` is high.
- `cpu_bus_idle` in 1 — CPU is not using the memory bus this cycle.
- `cpu_hold` out 1 — CPU must not start memory cycles.
- `cpu_ack` out 1 — one-cycle completion pulse.
- `cpu_cc` out [0:1] — condition code; valid while `cpu_ack` is high, and holds its value until the next ack.
- `iop_active` out 1 — connects to the IOP `active` input, which gives the IOP ownership of the memory bus.
- `iop_func` out [0:2] — drives the IOP function input.
- `iop_addr` out [0:2] — drives the IOP address input.
- `iop_cc` in [0:1] — condition code from the IOP.

## Operation
- Function codes:
  - SIO=0, TIO=1, TDV=2, HIO=3, AIO=6 are valid.
  - 4, 5 and 7 are invalid.
- Every output is registered. Reset values: `cpu_hold`=0, `cpu_ack`=0, `cpu_cc`=00, `iop_active`=0, `iop_func`=0, `iop_addr`=0. Reset puts the FSM in IDLE and the counter at 0.
- FSM states: IDLE, WAIT_BUS, ACTIVE, RESPOND, DRAIN.
- IDLE, `cpu_req`=1: latch `cpu_func`/`cpu_addr` into `iop_func`/`iop_addr`.
  - Invalid function, or `cpu_addr`≠`IOP_ADDR` → RESPOND with `cpu_cc`=11. The IOP is never activated.
  - Otherwise → WAIT_BUS with `cpu_hold`=1.
- WAIT_BUS: stay until `cpu_bus_idle`=1. Then → ACTIVE with `iop_active`=1 and counter = N−1. N is `SIO_CYCLES` for SIO and `OTHER_CYCLES` otherwise.
- ACTIVE: decrement the counter each cycle. When the counter is 0 → RESPOND: `iop_active`=0, `cpu_hold`=0, `cpu_cc` ← `iop_cc` sampled on that edge, `cpu_ack`=1.
- RESPOND: `cpu_ack`=0 → DRAIN.
- DRAIN: stay until `cpu_req`=0 → IDLE. A request held high across completion is never re-executed.
- `iop_func`/`iop_addr` are held constant from acceptance until the next acceptance.
- `cpu_func`/`cpu_addr` changes after acceptance are ignored.

## Timing
- Let the request be accepted at edge E0.
- Valid request with `cpu_bus_idle` already 1:
  - `iop_active` is high for exactly N cycles, E1 to E1+N.
  - `cpu_ack` is high for the single cycle after E1+N.
  - Request-to-ack latency is N+1 cycles (5 for SIO).
- Each cycle `cpu_bus_idle` is 0 in WAIT_BUS adds one cycle of latency. There is no timeout.
- Invalid request: `cpu_ack` high for the cycle after E0+1. `cpu_hold` and `iop_active` stay 0.
- `cpu_hold` rises at E0 and falls on the same edge `iop_active` falls. `iop_active` is never high while `cpu_hold` is 0.
- `cpu_req` dropping before ack does not abort; the operation completes and the ack is still issued.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), `iop_active` drops, and the operation is lost with no ack. After reset release, a still-high `cpu_req` is accepted as a new request.

## Structure
- Shared package `io_defs`:
  - function code constants FNC_SIO/TIO/TDV/HIO/AIO;
  - CC_NO_IOP=2'b11;
  - FSM state encoding.
  - The IOP uses the same function constants.
- No sub-module; the counter is 3 bits wide, sized from max(`SIO_CYCLES`, `OTHER_CYCLES`).

## Test plan
- Reset held low with `cpu_req`=1 → every output at its reset value; no ack.
- SIO, addr 0, `cpu_bus_idle`=1, `iop_cc` driven 01 → `iop_active` high 4 cycles, `cpu_hold` high 5 cycles, `cpu_ack` one cycle at E0+5 with `cpu_cc`=01. The IOP writes `32100021` to word 0x2A and `0E000000` to word 0x21.
- TIO with `cpu_bus_idle` low for 3 cycles, then high → `iop_active` rises 3 cycles late, stays high for 1 cycle; ack at E0+5.
- `cpu_func`=5, then separately `cpu_addr`=3 → ack at E0+1 with `cpu_cc`=11; `iop_active`/`cpu_hold` never assert.
- `cpu_req` held high for 20 cycles after an SIO → exactly one ack. Drop `cpu_req` for 1 cycle, raise it again → second operation accepted.
- Reset pulsed during the 3rd ACTIVE cycle of an SIO → `iop_active`/`cpu_hold` drop asynchronously; no ack; FSM in IDLE.
